// File: rtl/des_sbox_bank.sv
// rtl/des_sbox_bank.sv - bank of runtime-loaded DES S-box lookups behind a stalling valid/ready pipeline
// Tables are written before commit; lookups are only accepted once loaded is set.
module des_sbox_bank #(
  parameter int NBOX = 8,
  parameter int LAT  = 2,
  parameter int BW   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [BW-1:0]        cfg_box,
  input  logic [5:0]           cfg_addr,
  input  logic [3:0]           cfg_data,
  input  logic                 cfg_commit,
  output logic                 loaded,
  output logic                 cfg_err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6*NBOX-1:0]    din,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NBOX-1:0]    dout
);

  logic [3:0]        tbl_q [NBOX][64];
  logic [3:0]        tbl_d [NBOX][64];
  logic              loaded_q, loaded_d;
  logic              cfg_err_q, cfg_err_d;
  logic              vld_q [LAT];
  logic              vld_d [LAT];
  logic [4*NBOX-1:0] dat_q [LAT];
  logic [4*NBOX-1:0] dat_d [LAT];
  logic [4*NBOX-1:0] lut;
  logic              box_ok, wr_ok, en, xfer;

  assign box_ok   = {1'b0, cfg_box} < (BW+1)'(NBOX);
  assign wr_ok    = cfg_we & ~loaded_q & box_ok;
  assign en       = ~vld_q[LAT-1] | out_ready;
  assign in_ready = loaded_q & en;
  assign xfer     = in_valid & in_ready;

  always_comb begin
    loaded_d  = loaded_q | cfg_commit;
    cfg_err_d = cfg_err_q | (cfg_we & (loaded_q | ~box_ok));
  end

  // A write in the commit cycle still lands: wr_ok looks at the registered loaded.
  always_comb begin
    tbl_d = tbl_q;
    for (int k = 0; k < NBOX; k++) begin
      if (wr_ok && cfg_box == BW'(k)) tbl_d[k][cfg_addr] = cfg_data;
    end
  end

  always_comb begin
    lut = '0;
    for (int k = 0; k < NBOX; k++) begin
      lut[4*k +: 4] = tbl_q[k][din[6*k +: 6]];
    end
  end

  // Data registers only load behind a valid bit so dout keeps its last word during bubbles.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (en) begin
      vld_d[0] = xfer;
      if (xfer) dat_d[0] = lut;
      for (int i = 1; i < LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loaded_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      for (int k = 0; k < NBOX; k++) begin
        for (int a = 0; a < 64; a++) tbl_q[k][a] <= 4'h0;
      end
      for (int i = 0; i < LAT; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      loaded_q  <= loaded_d;
      cfg_err_q <= cfg_err_d;
      tbl_q     <= tbl_d;
      vld_q     <= vld_d;
      dat_q     <= dat_d;
    end
  end

  assign loaded    = loaded_q;
  assign cfg_err   = cfg_err_q;
  assign out_valid = vld_q[LAT-1];
  assign dout      = dat_q[LAT-1];

endmodule
